// File: rtl/user_proj_example_ctr_if.sv
// Wishbone slave bus bundle between the management SoC and the counter user project.
interface user_proj_example_ctr_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_proj_example_ctr.sv
// Free-running up-counter readable/writable over Wishbone, observable and loadable via the
// logic analyzer, and mirrored onto the GPIO outputs.
module user_proj_example_ctr #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned IO_PADS = 38
) (
`ifdef USE_POWER_PINS
    inout  wire                  vccd1,
    inout  wire                  vssd1,
`endif
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_proj_example_ctr_if.slave wb,
    input  logic [127:0]         la_data_in,
    output logic [127:0]         la_data_out,
    input  logic [127:0]         la_oenb,
    input  logic [IO_PADS-1:0]   io_in,
    output logic [IO_PADS-1:0]   io_out,
    output logic [IO_PADS-1:0]   io_oeb,
    output logic [2:0]           irq
);

    logic [BITS-1:0] count_q, count_d;
    logic [31:0]     count_ext;
    logic [31:0]     wr_val;
    logic [BITS-1:0] la_mask;
    logic [31:0]     rdata_q;
    logic            ack_q;
    logic            valid;
    logic            wr_en;
    logic            la_en;

    assign valid   = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign wr_en   = ack_q & valid & wb.wbs_we_i;
    assign la_mask = ~la_oenb[32 +: BITS];
    assign la_en   = (la_mask != '0) & ~valid;

    always_comb begin
        count_ext = '0;
        count_ext[BITS-1:0] = count_q;
    end

    // Byte-lane merge: lanes without a select keep the current count byte.
    always_comb begin
        wr_val = count_ext;
        for (int i = 0; i < 4; i++) begin
            if (wb.wbs_sel_i[i]) wr_val[8*i +: 8] = wb.wbs_dat_i[8*i +: 8];
        end
    end

    always_comb begin
        count_d = count_q + BITS'(1);
        if (wr_en) begin
            count_d = wr_val[BITS-1:0];
        end else if (la_en) begin
            count_d = (count_q & ~la_mask) | (la_data_in[32 +: BITS] & la_mask);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            count_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            count_q <= count_d;
            ack_q   <= valid & ~ack_q;
            if (valid & ~ack_q) rdata_q <= count_ext;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = rdata_q;

    assign la_data_out = {count_ext, 96'b0};

    always_comb begin
        io_out = '0;
        io_out[BITS-1:0] = count_q;
    end

    // Pads are driven only once the design is out of reset.
    assign io_oeb = {IO_PADS{~wb_rst_i}};
    assign irq    = 3'b000;

    logic unused_inputs;
    assign unused_inputs = ^{io_in, wb.wbs_adr_i, la_data_in, la_oenb};

`ifdef USE_POWER_PINS
    logic unused_pwr;
    assign unused_pwr = vccd1 ^ vssd1;
`endif

endmodule

// File: tb/tb_user_proj_example_ctr.sv
// Scoreboard bench for the counter user project: stimulus queues expected results, a negedge
// monitor pops and compares them against the GPIO/LA mirrors and Wishbone acknowledges.
module tb_user_proj_example_ctr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] la_data_in;
    logic [127:0] la_data_out;
    logic [127:0] la_oenb;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    always #5 clk = ~clk;

    user_proj_example_ctr_if wb ();

    user_proj_example_ctr #(
        .BITS    (32),
        .IO_PADS (38)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wb          (wb),
        .la_data_in  (la_data_in),
        .la_data_out (la_data_out),
        .la_oenb     (la_oenb),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] cnt;
        logic        oeb;
    } cnt_exp_t;

    typedef struct {
        string       name;
        logic        is_read;
        logic [31:0] dat;
        int          due;
    } ack_exp_t;

    cnt_exp_t cnt_q[$];
    ack_exp_t ack_q[$];
    cnt_exp_t ce;
    ack_exp_t ae;
    int       n_vec = 0;
    int       n_err = 0;
    int       cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one queued count observation per cycle, one queued entry per acknowledge.
    always @(negedge clk) begin
        if (cnt_q.size() > 0) begin
            ce = cnt_q.pop_front();
            check({ce.name, " io_out"}, 128'(io_out), 128'({6'b0, ce.cnt}));
            check({ce.name, " la_out"}, la_data_out, {ce.cnt, 96'b0});
            check({ce.name, " io_oeb"}, 128'(io_oeb), 128'({38{ce.oeb}}));
            check({ce.name, " irq"}, 128'(irq), 128'(0));
        end
        if (wb.wbs_ack_o === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack=1 at cycle %0d, expected ack=0", cyc_n);
            end else begin
                ae = ack_q.pop_front();
                check({ae.name, " ack_cycle"}, 128'(cyc_n), 128'(ae.due));
                if (ae.is_read) check({ae.name, " rdata"}, 128'(wb.wbs_dat_o), 128'(ae.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cnt(input string name, input logic [31:0] cnt);
        cnt_q.push_back('{name: name, cnt: cnt, oeb: 1'b0});
    endtask

    task automatic wb_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'h0;
    endtask

    task automatic wb_write(input string name, input logic [31:0] data, input logic [3:0] sel,
                            input logic [31:0] exp_after);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = sel;
        wb.wbs_dat_i = data;
        ack_q.push_back('{name: name, is_read: 1'b0, dat: 32'h0, due: cyc_n + 1});
        tick();
        tick();
        wb_idle();
        expect_cnt(name, exp_after);
    endtask

    task automatic wb_read(input string name, input logic [31:0] exp_dat);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        ack_q.push_back('{name: name, is_read: 1'b1, dat: exp_dat, due: cyc_n + 1});
        tick();
        tick();
        wb_idle();
    endtask

    initial begin
        wb_idle();
        wb.wbs_adr_i = 32'h3000_0000;
        la_data_in   = '0;
        la_oenb      = '1;
        io_in        = '0;

        repeat (3) tick();
        cnt_q.push_back('{name: "in_reset", cnt: 32'h0, oeb: 1'b1});
        tick();
        rst_n = 1'b1;
        expect_cnt("released", 32'h0);
        tick(); expect_cnt("run1", 32'h1);
        tick(); expect_cnt("run2", 32'h2);
        tick(); expect_cnt("run3", 32'h3);

        wb_read("read_single", 32'h3);
        expect_cnt("after_read", 32'h5);
        tick();

        wb_write("wr_full", 32'h1234_5678, 4'hF, 32'h1234_5678);
        tick(); expect_cnt("wr_full_inc", 32'h1234_5679);
        tick();

        wb_write("prime", 32'h1122_3344, 4'hF, 32'h1122_3344);
        wb_write("wr_byte1", 32'hAABB_CCDD, 4'b0010, 32'h1122_CC45);
        tick(); expect_cnt("wr_byte1_inc", 32'h1122_CC46);

        // Held strobe: acks on cycles +1 and +3, each returning the count seen before that edge.
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        ack_q.push_back('{name: "held_ack0", is_read: 1'b1, dat: 32'h1122_CC46, due: cyc_n + 1});
        ack_q.push_back('{name: "held_ack1", is_read: 1'b1, dat: 32'h1122_CC48, due: cyc_n + 3});
        repeat (4) tick();
        wb_idle();
        expect_cnt("held_done", 32'h1122_CC4A);

        la_oenb[63:32]    = 32'h0;
        la_data_in[63:32] = 32'hFFFF_FFF0;
        tick(); expect_cnt("la_load0", 32'hFFFF_FFF0);
        tick(); expect_cnt("la_load1", 32'hFFFF_FFF0);
        la_oenb = '1;
        for (int i = 1; i < 16; i++) begin
            tick();
            expect_cnt("la_count", 32'hFFFF_FFF0 + 32'(i));
        end
        tick(); expect_cnt("wrap", 32'h0);

        la_oenb[39:32]    = 8'h00;
        la_data_in[63:32] = 32'h5555_55AB;
        tick(); expect_cnt("la_byte0", 32'h0000_00AB);
        la_oenb = '1;
        tick(); expect_cnt("la_byte0_inc", 32'h0000_00AC);

        la_oenb[63:32]    = 32'h0;
        la_data_in[63:32] = 32'h0F0F_0F0F;
        wb_write("wr_over_la", 32'hCAFE_BABE, 4'hF, 32'hCAFE_BABE);
        la_oenb = '1;
        tick(); expect_cnt("wr_over_la_inc", 32'hCAFE_BABF);

        la_oenb[63:32] = 32'h0;
        wb_read("read_over_la", 32'hCAFE_BABF);
        la_oenb = '1;
        expect_cnt("read_over_la_cnt", 32'hCAFE_BAC1);

        repeat (3) tick();
        check("ack_queue_drained", 128'(ack_q.size()), 128'(0));
        check("cnt_queue_drained", 128'(cnt_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/user_proj_example_ctr.md
Name: user_proj_example_ctr

Overview:
- Free-running up-counter user project for the Caravel user area; sits inside user_project_wrapper.
- Exposes the count through three paths:
  - a Wishbone slave that reads and writes the counter,
  - the logic analyzer (LA), which observes the count and can force-load it,
  - the GPIO outputs.
- No interrupts are generated.

Parameters:
- BITS, 32: counter width. Must satisfy BITS ≤ 32 and BITS ≤ IO_PADS.
- IO_PADS, 38: number of GPIO pads (the codebase's MPRJ_IO_PADS).

Ports:
- wb_clk_i  in  1  single system clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = in reset).
- vccd1, vssd1  inout  1  power/ground; present only under USE_POWER_PINS.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  address; ignored (the whole slave window maps to the counter).
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  128  LA data from the management SoC.
- la_data_out  out  128  LA data to the management SoC.
- la_oenb  in  128  LA output-enable, active-low (0 = SoC drives that bit).
- io_in  in  IO_PADS  unused.
- io_out  out  IO_PADS  GPIO out.
- io_oeb  out  IO_PADS  GPIO output-enable, active-low.
- irq  out  3  user interrupts.

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - count=0, ack register=0, rdata register=0.
  - io_oeb all 1 while in reset, all 0 otherwise (combinational from reset).
- valid = wbs_cyc_i & wbs_stb_i.
- Ack register:
  - Each clock: ack <= valid & ~ack.
  - wbs_ack_o = ack.
  - Ack rises one cycle after valid is first seen and lasts exactly one cycle.
  - If valid is held high, ack toggles 1,0,1,…
- Read: on the edge where ack is set (valid & ~ack), rdata <= zero-extended count. wbs_dat_o = rdata.
- Write: on the edge where ack=1 and valid & wbs_we_i:
  - For each byte i with wbs_sel_i[i]=1, count byte i <= wbs_dat_i byte i.
  - Bytes with sel=0 hold their value.
  - The count does not increment on that cycle.
- LA load:
  - la_mask = ~la_oenb[63:32] (BITS LSBs used).
  - Active when la_mask≠0 and valid=0.
  - Masked count bits <= la_data_in[32+k]; unmasked bits hold; no increment that cycle.
- Priority per clock: Wishbone write > LA load > count <= count+1.
- Counter wraps modulo 2^BITS (all-ones → 0).
- While valid=1 but no write is occurring (read or non-ack cycle), the counter keeps incrementing.
- la_data_out:
  - [127:96] = zero-extended count.
  - All other bits 0.
- io_out:
  - [BITS-1:0] = count.
  - Remaining bits 0.
- irq = 3'b000 always.
- Reset asserted mid-transaction: ack drops immediately; the transaction is lost; the master must retry.

Test Plan:
- Reset held low, release → count=0 on the first edge after release, then 1,2,3… on io_out[31:0] and la_data_out[127:96]; io_oeb=0 after release and all-ones during reset.
- Wishbone write 0x12345678 with sel=4'hF → ack one cycle after stb; the next cycle count=0x12345679.
- Partial write:
  - Prime count=0x11223344 via a sel=4'hF write.
  - Then write data 0xAABBCCDD with sel=4'b0010.
  - Expected: byte1=0xCC; other bytes keep their values at write time (LA disabled); the counter then continues incrementing.
- Wishbone read → wbs_dat_o equals the count sampled the cycle before ack; ack width exactly 1 cycle; a cyc/stb held high produces ack pattern 1,0,1.
- LA load:
  - Set la_oenb[63:32]=0 and la_data_in[63:32]=0xFFFFFFF0 with no Wishbone activity → count stays 0xFFFFFFF0.
  - Release la_oenb → count increments to 0xFFFFFFFF, then wraps to 0.
- Simultaneous Wishbone write and LA mask active → Wishbone value wins; LA is ignored while valid=1.
